// File: rtl/snd_mix4.sv
// snd_mix4 - four-channel signed audio mixer with per-channel gain and
// output saturation. It combines the FM, PSG and auxiliary sources into
// one signed sample stream. Every register advances only on cen.
//
// Optional feature macro: MIX_DCRM_EN
//   When defined, ch2 is treated as unsigned. It passes through a DC
//   blocker before alignment. When undefined, ch2 is signed and is used
//   directly.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   cen          clock enable; all state updates are qualified by it
//   ch0..ch3     channel samples, wN bits, MSB-aligned to wout internally
//   gain0..gain3 unsigned 4.4 gains (0x10 = 1.0)
//   mixed        saturated signed mix, two cen pulses after sampling
//   peak         set on the cen whose result saturated; held between cens

// Per-channel stage 1: registered signed sample * unsigned gain.
module snd_mix4_lane #(
    parameter int wout = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cen,
    input  logic [wout-1:0] smp,
    input  logic [7:0]      gain,
    output logic [wout+8:0] prod
);
    localparam int PW = wout + 9;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            prod <= '0;
        else if (cen)
            // Zero-extending the gain keeps it non-negative in the signed product.
            prod <= PW'($signed(smp)) * PW'($signed({1'b0, gain}));
    end
endmodule

module snd_mix4 #(
    parameter int w0   = 16,
    parameter int w1   = 16,
    parameter int w2   = 16,
    parameter int w3   = 16,
    parameter int wout = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cen,
    input  logic [w0-1:0]   ch0,
    input  logic [w1-1:0]   ch1,
    input  logic [w2-1:0]   ch2,
    input  logic [w3-1:0]   ch3,
    input  logic [7:0]      gain0,
    input  logic [7:0]      gain1,
    input  logic [7:0]      gain2,
    input  logic [7:0]      gain3,
    output logic [wout-1:0] mixed,
    output logic            peak
);
    localparam int NUM_CH = 4;
    localparam int PW     = wout + 9;
    localparam int SW     = wout + 11;

    logic [w2-1:0] x2;

`ifdef MIX_DCRM_EN
    // Leaky integrator: acc settles at 64*ch2, so acc>>6 tracks the DC level.
    // The integrator is bounded by 64*(2^w2-1)+63, so it never wraps.
    logic [w2+5:0]        acc;
    logic [w2-1:0]        dc;
    logic signed [w2+1:0] diff;
    logic signed [w2+1:0] x_max;
    logic signed [w2+1:0] x_min;

    assign dc    = acc[w2+5:6];
    assign diff  = $signed({2'b00, ch2}) - $signed({2'b00, dc});
    assign x_max = $signed({3'b000, {(w2-1){1'b1}}});
    assign x_min = $signed({3'b111, {(w2-1){1'b0}}});

    always_comb begin
        x2 = diff[w2-1:0];
        if (diff > x_max)
            x2 = x_max[w2-1:0];
        else if (diff < x_min)
            x2 = x_min[w2-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc <= '0;
        else if (cen)
            acc <= acc + {6'b0, ch2} - {6'b0, dc};
    end
`else
    assign x2 = ch2;
`endif

    // MSB alignment: shift left so the channel sign bit lands on bit wout-1.
    logic [NUM_CH-1:0][wout-1:0] al;
    logic [NUM_CH-1:0][7:0]      gn;
    logic [NUM_CH-1:0][PW-1:0]   prod;

    assign al[0] = wout'(ch0) << (wout - w0);
    assign al[1] = wout'(ch1) << (wout - w1);
    assign al[2] = wout'(x2)  << (wout - w2);
    assign al[3] = wout'(ch3) << (wout - w3);
    assign gn    = {gain3, gain2, gain1, gain0};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        snd_mix4_lane #(.wout(wout)) u_lane (
            .clk  (clk),
            .rstn (rstn),
            .cen  (cen),
            .smp  (al[i]),
            .gain (gn[i]),
            .prod (prod[i])
        );
    end

    // Stage 2: sum, drop the 4 gain fraction bits (floor), then saturate.
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] t;
    logic signed [SW-1:0] t_max;
    logic signed [SW-1:0] t_min;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            sum = sum + SW'($signed(prod[i]));
    end

    assign t     = sum >>> 4;
    assign t_max = $signed({12'h000, {(wout-1){1'b1}}});
    assign t_min = $signed({12'hFFF, {(wout-1){1'b0}}});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mixed <= '0;
            peak  <= 1'b0;
        end else if (cen) begin
            if (t > t_max) begin
                mixed <= t_max[wout-1:0];
                peak  <= 1'b1;
            end else if (t < t_min) begin
                mixed <= t_min[wout-1:0];
                peak  <= 1'b1;
            end else begin
                mixed <= t[wout-1:0];
                peak  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snd_mix4.sv
// tb_snd_mix4 - directed checks of snd_mix4 with w2=10.
// Covers reset, latency, gain scaling, saturation, truncation, hold,
// mid-stream reset and, under MIX_DCRM_EN, DC removal.
module tb_snd_mix4;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cen;
    logic [15:0] ch0, ch1, ch3;
    logic [9:0]  ch2;
    logic [7:0]  gain0, gain1, gain2, gain3;
    logic [15:0] mixed;
    logic        peak;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snd_mix4 #(.w0(16), .w1(16), .w2(10), .w3(16), .wout(16)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .cen   (cen),
        .ch0   (ch0),
        .ch1   (ch1),
        .ch2   (ch2),
        .ch3   (ch3),
        .gain0 (gain0),
        .gain1 (gain1),
        .gain2 (gain2),
        .gain3 (gain3),
        .mixed (mixed),
        .peak  (peak)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Pulse cen n times; inputs change and outputs are sampled on negedges.
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) cen = 1'b1;
            @(negedge clk) cen = 1'b0;
        end
    endtask

    task automatic set_in(input logic [15:0] c0, input logic [7:0] g0,
                          input logic [15:0] c1, input logic [7:0] g1,
                          input logic [9:0]  c2, input logic [7:0] g2,
                          input logic [15:0] c3, input logic [7:0] g3);
        ch0 = c0; gain0 = g0; ch1 = c1; gain1 = g1;
        ch2 = c2; gain2 = g2; ch3 = c3; gain3 = g3;
    endtask

    function automatic int smix();
        return int'($signed(mixed));
    endfunction

    initial begin
        int prev;
        rstn = 1'b0;
        cen  = 1'b1;
        set_in(16'd1000, 8'h10, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);

        // Reset with nonzero inputs and cen toggling high.
        repeat (4) @(negedge clk);
        chk("rst_mixed", smix(), 0);
        chk("rst_peak", int'(peak), 0);
        cen = 1'b0;
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_hold", smix(), 0);

        // Single channel at unity gain; one cen is not yet enough.
        pulse(1);
        chk("lat_1cen", smix(), 0);
        pulse(1);
        chk("unity", smix(), 1000);
        chk("unity_peak", int'(peak), 0);

        // 1000*2 + (-500)*1 = 1500
        set_in(16'd1000, 8'h20, -16'sd500, 8'h10, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(1);
        chk("two_ch_lat", smix(), 1000);
        pulse(1);
        chk("two_ch", smix(), 1500);

        // Positive saturation, then hold with cen low.
        set_in(16'h7000, 8'h40, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("sat_pos", smix(), 32767);
        chk("sat_pos_peak", int'(peak), 1);
        repeat (5) @(negedge clk);
        chk("peak_hold", int'(peak), 1);

        set_in(-16'sh7000, 8'h40, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("sat_neg", smix(), -32768);
        chk("sat_neg_peak", int'(peak), 1);

        // Full scale at unity sits exactly on the limits without saturating.
        set_in(16'h7FFF, 8'h10, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("max_exact", smix(), 32767);
        chk("max_exact_peak", int'(peak), 0);
        set_in(16'h8000, 8'h10, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("min_exact", smix(), -32768);
        chk("min_exact_peak", int'(peak), 0);

        // Gain 0 mutes loud inputs exactly.
        set_in(16'h7000, 8'h00, 16'h7000, 8'h00, 10'd0, 8'h00, 16'h9000, 8'h00);
        pulse(2);
        chk("mute", smix(), 0);

        // Floor rounding: 8/16 -> 0, -8/16 -> -1.
        set_in(16'd1, 8'h08, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("trunc_pos", smix(), 0);
        set_in(16'hFFFF, 8'h08, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("trunc_neg", smix(), -1);

        // 100 * 255 / 16 = 1593.75 -> 1593
        set_in(16'd100, 8'hFF, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("gain_ff", smix(), 1593);

        set_in(16'd0, 8'h00, 16'd0, 8'h00, 10'd0, 8'h00, -16'sd300, 8'h10);
        pulse(2);
        chk("ch3", smix(), -300);

`ifndef MIX_DCRM_EN
        // 10-bit ch2 = 1 aligns to 1<<6 = 64.
        set_in(16'd0, 8'h00, 16'd0, 8'h00, 10'sd1, 8'h10, 16'd0, 8'h00);
        pulse(2);
        chk("align_ch2", smix(), 64);
        repeat (10) @(negedge clk);
        chk("align_hold", smix(), 64);

        // 10000*3 + 100*64 = 36400 -> saturate
        set_in(16'd10000, 8'h10, 16'd10000, 8'h10, 10'd100, 8'h10, 16'd10000, 8'h10);
        pulse(2);
        chk("sum4_sat", smix(), 32767);
        chk("sum4_peak", int'(peak), 1);
`endif

        // Mid-stream reset clears output; the first valid result appears on the 2nd cen.
        set_in(16'd2000, 8'h10, 16'd0, 8'h00, 10'd0, 8'h00, 16'd0, 8'h00);
        pulse(2);
        chk("pre_rst", smix(), 2000);
        @(negedge clk) rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst", smix(), 0);
        rstn = 1'b1;
        pulse(1);
        chk("mid_rst_1cen", smix(), 0);
        pulse(1);
        chk("mid_rst_2cen", smix(), 2000);

`ifdef MIX_DCRM_EN
        // Constant 512 on ch2: the first output is 512 - 0, saturated to 511.
        // That gives 511 << 6 = 32704. After that the output only decays.
        set_in(16'd0, 8'h00, 16'd0, 8'h00, 10'd512, 8'h10, 16'd0, 8'h00);
        pulse(2);
        chk("dc_first", smix(), 32704);
        prev = smix();
        for (int i = 0; i < 200; i++) begin
            pulse(1);
            chk("dc_peak", int'(peak), 0);
            chk("dc_nonincr", int'(smix() <= prev && smix() >= 0), 1);
            prev = smix();
        end
        chk("dc_decayed", int'(smix() < 8000), 1);
`else
        prev = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
